// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub mode encodings and the serial unit's FSM states.
package alu_pkg;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit ripple add/subtract slice.
// cin/cout are in the external sense: carry for add, borrow for subtract.
// Internally subtract is a + ~b + ~borrow, so the carry chain is always a plain adder.
module addsub_slice
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic             sub;
    logic [DIGIT-1:0] bx;
    logic [DIGIT:0]   c;

    assign sub  = (mode == MODE_SUB);
    assign bx   = sub ? ~b : b;
    assign c[0] = cin ^ sub;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign s[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    // Borrow is the inverse of the internal carry in subtract mode.
    assign cout  = c[DIGIT] ^ sub;
    // Internal-sense carry into the top cell; used for signed overflow.
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit. Operands are consumed LSB digit first,
// one DIGIT-wide slice per clock; result and flags are published on out_done.
// WIDTH must be a multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_borrow,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_result,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = $clog2(NSLICE) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               cy;
    logic               mode_r;
    logic               ovf_r;

    logic [DIGIT-1:0]       sl_s;
    logic                   sl_cout;
    logic                   sl_cmsb;
    logic                   sl_ovf;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic                   accept;

    addsub_slice #(.DIGIT(DIGIT)) u_slice (
        .a     (a_sr[DIGIT-1:0]),
        .b     (b_sr[DIGIT-1:0]),
        .cin   (cy),
        .mode  (mode_r),
        .s     (sl_s),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // Overflow is carry-in xor carry-out of the top cell, both in internal adder sense.
    // Only the value from the final slice is ever published.
    assign sl_ovf = sl_cmsb ^ sl_cout ^ (mode_r == MODE_SUB);

    // New digit enters at the top; after NSLICE shifts the first digit sits at bit 0.
    assign res_cat = {sl_s, res_sr};

    // A request is only seen while not busy (IDLE, or the DONE cycle for back-to-back).
    assign accept = in_start && (state == IDLE || state == DONE);

    // FSM, operand/result shift registers, counter and registered outputs.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cy         <= 1'b0;
            mode_r     <= MODE_SUB;
            ovf_r      <= 1'b0;
            out_busy   <= 1'b0;
            out_done   <= 1'b0;
            out_result <= '0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                RUN: begin
                    res_sr <= res_cat[WIDTH+DIGIT-1:DIGIT];
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    cy     <= sl_cout;
                    ovf_r  <= sl_ovf;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        out_busy <= 1'b0;
                    end
                end
                DONE: begin
                    out_done   <= 1'b1;
                    out_result <= res_sr;
                    out_borrow <= cy;
                    out_zero   <= (res_sr == '0);
                    out_ovf    <= ovf_r;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Capture overrides the state update above so DONE can chain straight into RUN.
            if (accept) begin
                a_sr     <= in_a;
                b_sr     <= in_b;
                mode_r   <= in_mode;
                cy       <= in_borrow;
                cnt      <= '0;
                out_busy <= 1'b1;
                state    <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases on a 16/4 instance plus a
// parallel random sweep over several WIDTH/DIGIT configurations.
module tb_serial_addsub;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic        brw;
        logic        zero;
        logic        ovf;
    } exp_t;

    localparam int NCFG = 6;
    localparam int CFG_W [NCFG] = '{16, 16, 16, 8, 8, 8};
    localparam int CFG_D [NCFG] = '{1, 2, 16, 1, 2, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, brw, zero, ovf;
    logic [15:0] res;

    logic        sw_start = 1'b0;
    logic        sw_mode = 1'b0;
    logic        sw_cin = 1'b0;
    logic [15:0] sw_a = '0;
    logic [15:0] sw_b = '0;
    logic [NCFG-1:0]       sw_busy, sw_done, sw_brw, sw_zero, sw_ovf;
    logic [NCFG-1:0][15:0] sw_res;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    exp_t sw_q[NCFG][$];

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_mode(mode),
        .in_a(a), .in_b(b), .in_borrow(cin),
        .out_busy(busy), .out_done(done), .out_result(res),
        .out_borrow(brw), .out_zero(zero), .out_ovf(ovf)
    );

    for (genvar k = 0; k < NCFG; k++) begin : g_sw
        localparam int W = CFG_W[k];
        localparam int D = CFG_D[k];
        logic [W-1:0] r;
        serial_addsub #(.WIDTH(W), .DIGIT(D)) u_sw (
            .in_clk(clk), .in_rst(rst), .in_start(sw_start), .in_mode(sw_mode),
            .in_a(sw_a[W-1:0]), .in_b(sw_b[W-1:0]), .in_borrow(sw_cin),
            .out_busy(sw_busy[k]), .out_done(sw_done[k]), .out_result(r),
            .out_borrow(sw_brw[k]), .out_zero(sw_zero[k]), .out_ovf(sw_ovf[k])
        );
        assign sw_res[k] = 16'(r);
    end

    // Arithmetic reference straight from the definition, for width w.
    function automatic exp_t model(input int w, input logic md, input logic [15:0] x,
                                   input logic [15:0] y, input logic c);
        exp_t        e;
        logic [15:0] mask;
        logic [16:0] full;
        int          msb;
        mask = 16'((17'd1 << w) - 17'd1);
        x    = x & mask;
        y    = y & mask;
        msb  = w - 1;
        if (md == MODE_ADD) begin
            full  = {1'b0, x} + {1'b0, y} + 17'(c);
            e.res = full[15:0] & mask;
            e.brw = full[w];
            e.ovf = (x[msb] == y[msb]) && (e.res[msb] != x[msb]);
        end else begin
            full  = {1'b0, x} - {1'b0, y} - 17'(c);
            e.res = full[15:0] & mask;
            e.brw = ({1'b0, x} < ({1'b0, y} + 17'(c)));
            e.ovf = (x[msb] != y[msb]) && (e.res[msb] != x[msb]);
        end
        e.zero = (e.res == 16'h0);
        return e;
    endfunction

    function automatic string show(input exp_t x);
        return $sformatf("res=%h brw=%b zero=%b ovf=%b", x.res, x.brw, x.zero, x.ovf);
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Pulse start for one edge; returns at the negedge right after the sampling edge.
    task automatic issue(input logic m, input logic [15:0] x, input logic [15:0] y, input logic c);
        @(negedge clk);
        mode = m; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count edges until out_done is seen (-1 if it never comes within max edges).
    task automatic wait_done(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_op(input logic m, input logic [15:0] x, input logic [15:0] y, input logic c,
                         input exp_t e, output int n, output exp_t got, output exp_t want);
        sbq.push_back(e);
        issue(m, x, y, c);
        wait_done(12, n);
        got  = {res, brw, zero, ovf};
        want = sbq.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, res, brw, zero, ovf} !== 21'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h brw=%b zero=%b ovf=%b, want all 0",
                     busy, done, res, brw, zero, ovf);
        end
        total++;
        if ({sw_busy, sw_done, sw_res, sw_brw, sw_zero, sw_ovf} !== '0) begin
            bad++;
            $display("FAIL reset_sweep: got busy=%b done=%b brw=%b, want all 0", sw_busy, sw_done, sw_brw);
        end
        rst = 1'b0;
    endtask

    task automatic test_sub();
        exp_t got, want;
        int   n;
        logic [15:0] ta [2] = '{16'h0000, 16'h8000};
        exp_t        te [2] = '{{16'hFFFF, 1'b1, 1'b0, 1'b0}, {16'h7FFF, 1'b0, 1'b0, 1'b1}};
        sbq.push_back({16'h1000, 1'b0, 1'b0, 1'b0});
        issue(MODE_SUB, 16'h1234, 16'h0234, 1'b0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || res !== 16'h0000) begin
            bad++;
            $display("FAIL sub_run_state: got busy=%b done=%b res=%h, want busy=1 done=0 res=0000", busy, done, res);
        end
        wait_done(12, n);
        got  = {res, brw, zero, ovf};
        want = sbq.pop_front();
        total++;
        if (n != 5) begin bad++; $display("FAIL sub_latency: got %0d edges, want 5", n); end
        total++;
        if (got !== want) begin bad++; $display("FAIL sub_basic: got %s, want %s", show(got), show(want)); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL sub_busy_at_done: got %b, want 0", busy); end
        for (int i = 0; i < 2; i++) begin
            do_op(MODE_SUB, ta[i], 16'h0001, 1'b0, te[i], n, got, want);
            total++;
            if (n != 5) begin bad++; $display("FAIL sub_edge%0d_latency: got %0d, want 5", i, n); end
            total++;
            if (got !== want) begin bad++; $display("FAIL sub_edge%0d: got %s, want %s", i, show(got), show(want)); end
        end
    endtask

    task automatic test_add();
        exp_t got, want;
        int   n;
        logic [15:0] ta [2] = '{16'h7FFF, 16'hFFFF};
        exp_t        te [2] = '{{16'h8000, 1'b0, 1'b0, 1'b1}, {16'h0000, 1'b1, 1'b1, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            do_op(MODE_ADD, ta[i], 16'h0001, 1'b0, te[i], n, got, want);
            total++;
            if (n != 5) begin bad++; $display("FAIL add%0d_latency: got %0d, want 5", i, n); end
            total++;
            if (got !== want) begin bad++; $display("FAIL add%0d: got %s, want %s", i, show(got), show(want)); end
        end
    endtask

    task automatic test_chain();
        exp_t got, want;
        int   n;
        do_op(MODE_SUB, 16'h0005, 16'h0005, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0}, n, got, want);
        total++;
        if (got !== want) begin bad++; $display("FAIL chain_lo: got %s, want %s", show(got), show(want)); end
        // Borrow-out of the low word feeds the high word.
        do_op(MODE_SUB, 16'h0001, 16'h0000, brw, {16'h0000, 1'b0, 1'b1, 1'b0}, n, got, want);
        total++;
        if (got !== want) begin bad++; $display("FAIL chain_hi: got %s, want %s", show(got), show(want)); end
    endtask

    task automatic test_ignore_start();
        exp_t got, want;
        int   n;
        logic seen;
        sbq.push_back({16'h1F1F, 1'b0, 1'b0, 1'b0});
        issue(MODE_ADD, 16'h0F0F, 16'h1010, 1'b0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        mode = MODE_SUB; a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(12, n);
        got  = {res, brw, zero, ovf};
        want = sbq.pop_front();
        total++;
        if (n != 2) begin bad++; $display("FAIL ignore_latency: got %0d more edges, want 2", n); end
        total++;
        if (got !== want) begin bad++; $display("FAIL ignore_result: got %s, want %s", show(got), show(want)); end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL ignore_extra_op: got busy/done activity=1, want 0"); end
    endtask

    task automatic test_back_to_back();
        exp_t got, want;
        int   n;
        sbq.push_back({16'h00FF, 1'b0, 1'b0, 1'b0});
        issue(MODE_SUB, 16'h0100, 16'h0001, 1'b0);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_state: got busy=%b done=%b, want 0 0", busy, done);
        end
        sbq.push_back({16'h8000, 1'b0, 1'b0, 1'b1});
        mode = MODE_ADD; a = 16'h4000; b = 16'h4000; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        got  = {res, brw, zero, ovf};
        want = sbq.pop_front();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b, want 1", done); end
        total++;
        if (got !== want) begin bad++; $display("FAIL b2b_first: got %s, want %s", show(got), show(want)); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b, want 1", busy); end
        wait_done(12, n);
        got  = {res, brw, zero, ovf};
        want = sbq.pop_front();
        total++;
        if (n != 5) begin bad++; $display("FAIL b2b_latency: got %0d, want 5", n); end
        total++;
        if (got !== want) begin bad++; $display("FAIL b2b_second: got %s, want %s", show(got), show(want)); end
    endtask

    task automatic test_reset_abort();
        exp_t got, want;
        int   n;
        logic seen;
        do_op(MODE_ADD, 16'h1111, 16'h2222, 1'b0, {16'h3333, 1'b0, 1'b0, 1'b0}, n, got, want);
        total++;
        if (got !== want) begin bad++; $display("FAIL abort_setup: got %s, want %s", show(got), show(want)); end
        issue(MODE_ADD, 16'h1234, 16'h4321, 1'b0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, res, brw, zero, ovf} !== 21'd0) begin
            bad++;
            $display("FAIL abort_clear: got busy=%b done=%b res=%h brw=%b zero=%b ovf=%b, want all 0",
                     busy, done, res, brw, zero, ovf);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL abort_no_done: got done=1 after reset, want none"); end
    endtask

    task automatic test_sweep();
        exp_t got, want;
        logic [NCFG-1:0] seen;
        int lat;
        for (int op = 0; op < 1000; op++) begin
            @(negedge clk);
            sw_a = rnd16(); sw_b = rnd16(); sw_mode = 1'($urandom); sw_cin = 1'($urandom);
            sw_start = 1'b1;
            for (int k = 0; k < NCFG; k++) sw_q[k].push_back(model(CFG_W[k], sw_mode, sw_a, sw_b, sw_cin));
            @(posedge clk);
            @(negedge clk);
            sw_start = 1'b0;
            seen = '0;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk);
                @(negedge clk);
                for (int k = 0; k < NCFG; k++) begin
                    if (sw_done[k] === 1'b1 && !seen[k]) begin
                        seen[k] = 1'b1;
                        lat = CFG_W[k] / CFG_D[k] + 1;
                        total++;
                        if (n != lat) begin
                            bad++;
                            $display("FAIL sweep_latency W=%0d D=%0d op=%0d: got %0d, want %0d", CFG_W[k], CFG_D[k], op, n, lat);
                        end
                        want = sw_q[k].pop_front();
                        got  = {sw_res[k], sw_brw[k], sw_zero[k], sw_ovf[k]};
                        total++;
                        if (got !== want) begin
                            bad++;
                            $display("FAIL sweep_result W=%0d D=%0d op=%0d a=%h b=%h m=%b c=%b: got %s, want %s",
                                     CFG_W[k], CFG_D[k], op, sw_a, sw_b, sw_mode, sw_cin, show(got), show(want));
                        end
                    end
                end
                if (&seen) break;
            end
            for (int k = 0; k < NCFG; k++) begin
                if (!seen[k]) begin
                    total++;
                    bad++;
                    $display("FAIL sweep_timeout W=%0d D=%0d op=%0d: got no done, want one", CFG_W[k], CFG_D[k], op);
                    sw_q[k].delete();
                end
            end
            total++;
            if (sw_busy !== '0) begin bad++; $display("FAIL sweep_idle op=%0d: got busy=%b, want 0", op, sw_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add();
        test_chain();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
